// File: rtl/mem_readback_pkg.sv
// Shared types and constants for the flash readback path (FSM states, word geometry).
// The flash writer and benches reuse WORD_BYTES as the address stride.
package mem_readback_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    FINISH
  } state_t;

  localparam int MEM_WIDTH      = 32;
  localparam int BYTES_PER_WORD = MEM_WIDTH / 8;
  localparam int WORD_BYTES     = 4;

endpackage

// File: rtl/mem_readback_word_serializer.sv
// Holds one memory word and emits it little-endian, a byte per accepted handshake.
// Zero-latency valid while active; out_data holds still until out_ready.
module word_serializer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             active,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             last_byte
);

  localparam int BPW   = WIDTH / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [WIDTH-1:0] word_reg;
  logic [IDX_W-1:0] byte_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_reg <= '0;
      byte_idx <= '0;
    end else if (load) begin
      word_reg <= load_data;
      byte_idx <= '0;
    end else if (active && out_ready && !last_byte) begin
      byte_idx <= byte_idx + 1'b1;
    end
  end

  assign last_byte = (byte_idx == IDX_W'(BPW - 1));
  assign out_valid = active;
  assign out_data  = word_reg[{byte_idx, 3'b000} +: 8];

endmodule

// File: rtl/mem_readback.sv
// Reads num_words words from base_addr and streams them out byte by byte.
// First byte 3 cycles after start; a stalled consumer simply holds the FSM in SEND.
module mem_readback
  import mem_readback_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] num_words,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]      mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  busy,
  output logic                  done
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] words_left;
  logic                  last_byte;
  logic                  word_done;

  assign word_done = (state == SEND) && out_ready && last_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      words_left <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        // Reads are always word aligned regardless of the caller's low bits.
        addr       <= base_addr & ~ADDR_WIDTH'(3);
        words_left <= num_words;
      end else if (word_done) begin
        addr       <= addr + ADDR_WIDTH'(WORD_BYTES);
        words_left <= words_left - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_words == '0) ? FINISH : READ;
      READ:    state_nxt = WAIT;
      WAIT:    state_nxt = SEND;
      SEND:    if (word_done) state_nxt = (words_left > 1) ? READ : FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_rd_en   = (state == READ);
  assign mem_rd_addr = addr;
  assign busy        = (state != IDLE);
  assign done        = (state == FINISH);

  word_serializer #(.WIDTH(WIDTH)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (state == WAIT),
    .load_data (mem_rd_data),
    .active    (state == SEND),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .last_byte (last_byte)
  );

endmodule

// File: tb/tb_mem_readback.sv
// Directed scoreboard bench: expected bytes/read addresses queued by stimulus, checked by a monitor.
module tb_mem_readback;
  import mem_readback_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] base_addr = '0;
  logic [10:0] num_words = '0;
  logic        mem_rd_en;
  logic [10:0] mem_rd_addr;
  logic [31:0] mem_rd_data = '0;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic        done;

  mem_readback #(.WIDTH(32), .ADDR_WIDTH(11)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [512];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[10:2]];

  int total = 0;
  int bad = 0;
  int ncyc = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int rd_first = -1;
  int vld_first = -1;
  bit tog = 0;
  bit prev_stall = 0;
  logic [7:0] prev_data = '0;
  logic [7:0]  exp_bytes[$];
  logic [10:0] exp_addrs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = tog ? ~out_ready : 1'b1;
    end
  end

  // Monitor: everything observed mid-cycle on the falling edge.
  always @(negedge clk) begin
    ncyc++;
    if (done) done_cnt++;
    if (out_valid && vld_first < 0) vld_first = ncyc;
    if (prev_stall && out_valid) check("stall_hold", {24'd0, out_data}, {24'd0, prev_data});
    if (mem_rd_en) begin
      if (rd_first < 0) rd_first = ncyc;
      check("rd_while_valid", {31'd0, out_valid}, 32'd0);
      if (exp_addrs.size() == 0) check("rd_unexpected", {21'd0, mem_rd_addr}, 32'hFFFF);
      else check("rd_addr", {21'd0, mem_rd_addr}, {21'd0, exp_addrs.pop_front()});
    end
    if (out_valid && out_ready) begin
      acc_cnt++;
      if (exp_bytes.size() == 0) check("byte_unexpected", {24'd0, out_data}, 32'h1FF);
      else check("byte", {24'd0, out_data}, {24'd0, exp_bytes.pop_front()});
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  end

  task automatic push4(input logic [7:0] b0, b1, b2, b3);
    exp_bytes.push_back(b0); exp_bytes.push_back(b1);
    exp_bytes.push_back(b2); exp_bytes.push_back(b3);
  endtask

  task automatic kick(input logic [10:0] base, input logic [10:0] num, output int k);
    @(negedge clk);
    #1;
    base_addr = base;
    num_words = num;
    start = 1'b1;
    rd_first = -1;
    vld_first = -1;
    k = ncyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 300; i++) begin
      if (done_cnt >= target) break;
      @(negedge clk);
      #2;
    end
    if (done_cnt < target) begin
      bad++;
      total++;
      $display("FAIL done_timeout: got %0d done pulses expected %0d", done_cnt, target);
    end
    repeat (2) @(negedge clk);
    #2;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    check("bytes_left", exp_bytes.size(), 0);
    check("reads_left", exp_addrs.size(), 0);
  endtask

  int k, d0, a0;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[0]   = 32'h0000_3039;
    mem[1]   = 32'h000A_5BFE;
    mem[511] = 32'hDDCC_BBAA;

    repeat (3) @(negedge clk);
    #2;
    check("rst_rd_en", {31'd0, mem_rd_en}, 0);
    check("rst_rd_addr", {21'd0, mem_rd_addr}, 0);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_data", {24'd0, out_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    rst = 1'b0;

    // Two words, consumer always ready.
    push4(8'h39, 8'h30, 8'h00, 8'h00); push4(8'hFE, 8'h5B, 8'h0A, 8'h00);
    exp_addrs.push_back(11'h000); exp_addrs.push_back(11'h004);
    d0 = done_cnt; a0 = acc_cnt;
    kick(11'h000, 11'd2, k);
    wait_done(d0 + 1);
    check("rd_latency", rd_first - k, 1);
    check("vld_latency", vld_first - k, 3);
    check("done_once", done_cnt - d0, 1);
    check("byte_count", acc_cnt - a0, 8);

    // Same image with a stalling consumer.
    tog = 1;
    push4(8'h39, 8'h30, 8'h00, 8'h00); push4(8'hFE, 8'h5B, 8'h0A, 8'h00);
    exp_addrs.push_back(11'h000); exp_addrs.push_back(11'h004);
    d0 = done_cnt;
    kick(11'h000, 11'd2, k);
    wait_done(d0 + 1);
    tog = 0;
    check("toggle_done_once", done_cnt - d0, 1);

    // Empty block.
    d0 = done_cnt;
    kick(11'h000, 11'd0, k);
    wait_done(d0 + 1);
    check("zero_no_read", rd_first, -1);
    check("zero_no_valid", vld_first, -1);
    check("zero_done_once", done_cnt - d0, 1);

    // Address wrap at the top of the flash.
    push4(8'hAA, 8'hBB, 8'hCC, 8'hDD); push4(8'h39, 8'h30, 8'h00, 8'h00);
    exp_addrs.push_back(11'h7FC); exp_addrs.push_back(11'h000);
    d0 = done_cnt;
    kick(11'h7FC, 11'd2, k);
    wait_done(d0 + 1);

    // Unaligned base is rounded down.
    push4(8'hFE, 8'h5B, 8'h0A, 8'h00);
    exp_addrs.push_back(11'h004);
    d0 = done_cnt;
    kick(11'h006, 11'd1, k);
    wait_done(d0 + 1);

    // Reset in the middle of the first word.
    push4(8'h39, 8'h30, 8'h00, 8'h00); push4(8'hFE, 8'h5B, 8'h0A, 8'h00);
    exp_addrs.push_back(11'h000); exp_addrs.push_back(11'h004);
    d0 = done_cnt; a0 = acc_cnt;
    kick(11'h000, 11'd2, k);
    for (int i = 0; i < 50 && acc_cnt < a0 + 2; i++) begin
      @(negedge clk);
      #2;
    end
    check("pre_rst_bytes", acc_cnt - a0, 2);
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, out_valid}, 0);
    check("arst_data", {24'd0, out_data}, 0);
    check("arst_rd_en", {31'd0, mem_rd_en}, 0);
    check("arst_rd_addr", {21'd0, mem_rd_addr}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    exp_bytes.delete();
    exp_addrs.delete();
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("arst_no_done", done_cnt - d0, 0);
    check("arst_no_bytes", acc_cnt - a0, 2);
    push4(8'h39, 8'h30, 8'h00, 8'h00);
    exp_addrs.push_back(11'h000);
    kick(11'h000, 11'd1, k);
    wait_done(d0 + 1);
    check("restart_latency", vld_first - k, 3);

    // A second start while busy must be ignored.
    push4(8'h39, 8'h30, 8'h00, 8'h00); push4(8'hFE, 8'h5B, 8'h0A, 8'h00);
    exp_addrs.push_back(11'h000); exp_addrs.push_back(11'h004);
    d0 = done_cnt; a0 = acc_cnt;
    kick(11'h000, 11'd2, k);
    repeat (4) @(negedge clk);
    #1;
    base_addr = 11'h7FC;
    num_words = 11'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(d0 + 1);
    repeat (5) @(negedge clk);
    #2;
    check("busy_start_bytes", acc_cnt - a0, 8);
    check("busy_start_done", done_cnt - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
